lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
Display timing stage for the 800x480 LCD panel. It generates the pixel scan counters x_cnt/y_cnt that drive Menu_game and the in-game renderers, and consumes their registered 24-bit colour output. Sync and data-enable are delayed to match the renderer pipeline latency, and RGB is blanked outside the active area, so pixel colour and panel strobes leave the chip aligned.

Parameters:
H_ACTIVE, 800, active pixels per line
H_FRONT, 210, horizontal front porch (pixels)
H_SYNC, 1, horizontal sync width (pixels)
H_BACK, 45, horizontal back porch (pixels); H_TOTAL = 1056
V_ACTIVE, 480, active lines per frame
V_FRONT, 22, vertical front porch (lines)
V_SYNC, 1, vertical sync width (lines)
V_BACK, 22, vertical back porch (lines); V_TOTAL = 525
PIPE_DELAY, 3, renderer latency in clk cycles from x_cnt/y_cnt to pixel_rgb; legal range 1..8

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_en  in  1  pixel-rate enable; counters advance only when high
pixel_rgb  in  24  colour from the renderer ({R,G,B}), valid PIPE_DELAY clk after the matching counters
x_cnt  out  11  horizontal scan position, 0..H_TOTAL-1
y_cnt  out  10  vertical scan position, 0..V_TOTAL-1
frame_start  out  1  one-clk pulse when the counters are at (0,0) after a wrap
lcd_hsd  out  1  horizontal sync, active-low
lcd_vsd  out  1  vertical sync, active-low
lcd_de  out  1  data enable, active-high
lcd_rgb  out  24  panel colour, zero when lcd_de is low

Behaviour:
- Reset: one clk, synchronous, active-high. x_cnt=0, y_cnt=0, frame_start=0, lcd_hsd=1, lcd_vsd=1, lcd_de=0, lcd_rgb=0. All delay-line stages are cleared to the inactive values. Reset mid-frame aborts the frame immediately.
- Counters, on each clk with pix_en=1:
  - x_cnt increments; at H_TOTAL-1 it wraps to 0 and y_cnt increments.
  - y_cnt wraps to 0 at V_TOTAL-1 when x_cnt also wraps.
  - With pix_en=0, both counters hold.
- Region decode, combinational from the counters:
  - de_raw = (x_cnt < H_ACTIVE) && (y_cnt < V_ACTIVE).
  - hs_raw low for H_ACTIVE+H_FRONT <= x_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw low for V_ACTIVE+V_FRONT <= y_cnt < V_ACTIVE+V_FRONT+V_SYNC, for the whole line.
  - All comparisons are unsigned at counter width; parameter sums are computed as 12-bit constants.
- Delay line: {hs_raw, vs_raw, de_raw} pass through PIPE_DELAY clk-stage registers. The line shifts every clk, independent of pix_en, because the renderer pipeline is clocked every clk.
- Output register, every clk:
  - lcd_hsd, lcd_vsd, lcd_de take the last delay stage.
  - lcd_rgb = delayed_de ? pixel_rgb : 24'h0.
  - Total latency from the counter value to the lcd_* outputs is PIPE_DELAY+1 clk.
- frame_start:
  - Registered. High for exactly one clk, in the first clk where the counters read (0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the post-reset (0,0).
  - If pix_en stays low after the wrap, the pulse is still only one clk.
- Requirement on pix_en: the pix_en period must be at least 1 clk. For pix_en < 1 per clk, the renderer sees each counter value for several clks, and the alignment above still holds per clk.
- No back-pressure. pixel_rgb is sampled unconditionally.

Decomposition:
- Package lcd_timing_pkg holds the default timing constants, the derived totals and sync start/end positions, and the blank colour 24'h0.
- One sub-module, sync_delay_line: a parameterised depth×width shift register with a synchronous reset value input, used for {hs,vs,de}.
- Counter and decode logic stays in lcd_timing_gen.

Test Plan:
1. Reset, then pix_en=1 for 1056 clk -> x_cnt runs 0..1055 and returns to 0; y_cnt steps 0->1 on the wrap clk.
2. Run a full frame (1056×525 clk) -> frame_start pulses once, when (x,y)=(0,0), 554400 clk after reset release; no pulse at reset release.
3. Drive pixel_rgb = {x_cnt[7:0], y_cnt[7:0], 8'hA5} delayed by 3 clk -> lcd_rgb at x=0,y=0 equals 24'h0000A5 four clk after the counters read (0,0); lcd_rgb=0 while x_cnt=800..1055.
4. Check sync timing -> lcd_hsd is low for exactly 1 clk when x_cnt was 1010, seen at the output 4 clk later; lcd_vsd is low for 1056 clk covering y_cnt=502.
5. pix_en toggled 1-of-2 -> counters advance every other clk; one line takes 2112 clk; lcd_de high for 1600 clk per active line.
6. Assert reset at x=400,y=200 -> next clk x_cnt=0, y_cnt=0, lcd_de=0, lcd_rgb=0, lcd_hsd=lcd_vsd=1; the next frame_start comes only after a full frame.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Default 800x480 panel timing, derived totals and sync windows, and the blank colour.
package lcd_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF   = 800;
    localparam int unsigned H_FRONT_DEF    = 210;
    localparam int unsigned H_SYNC_DEF     = 1;
    localparam int unsigned H_BACK_DEF     = 45;
    localparam int unsigned V_ACTIVE_DEF   = 480;
    localparam int unsigned V_FRONT_DEF    = 22;
    localparam int unsigned V_SYNC_DEF     = 1;
    localparam int unsigned V_BACK_DEF     = 22;
    localparam int unsigned PIPE_DELAY_DEF = 3;

    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FRONT_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FRONT_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    localparam logic [23:0] BLANK_RGB = 24'h0;

    // Timing sums are carried as 12-bit constants before narrowing to counter width.
    function automatic logic [11:0] sum12(input int unsigned a, input int unsigned b);
        return 12'(a + b);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Depth x width shift register with a synchronous reset-to-value, shifted every clk.
module sync_delay_line #(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] rst_val,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= rst_val;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[Depth-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD scan counters, sync/DE decode delayed to renderer latency, and blanked RGB output.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FRONT    = H_FRONT_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BACK     = H_BACK_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FRONT    = V_FRONT_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BACK     = V_BACK_DEF,
    parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [23:0] pixel_rgb,
    output logic [10:0] x_cnt,
    output logic [9:0]  y_cnt,
    output logic        frame_start,
    output logic        lcd_hsd,
    output logic        lcd_vsd,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb
);

    localparam logic [11:0] H_ACT    = sum12(H_ACTIVE, 0);
    localparam logic [11:0] HS_START = sum12(H_ACTIVE, H_FRONT);
    localparam logic [11:0] HS_END   = sum12(H_ACTIVE + H_FRONT, H_SYNC);
    localparam logic [11:0] H_LAST   = sum12(H_ACTIVE + H_FRONT + H_SYNC, H_BACK) - 12'd1;
    localparam logic [11:0] V_ACT    = sum12(V_ACTIVE, 0);
    localparam logic [11:0] VS_START = sum12(V_ACTIVE, V_FRONT);
    localparam logic [11:0] VS_END   = sum12(V_ACTIVE + V_FRONT, V_SYNC);
    localparam logic [11:0] V_LAST   = sum12(V_ACTIVE + V_FRONT + V_SYNC, V_BACK) - 12'd1;

    logic       de_raw;
    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] sync_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (x_cnt == 11'(H_LAST)) begin
                    x_cnt <= '0;
                    if (y_cnt == 10'(V_LAST)) begin
                        y_cnt       <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        y_cnt <= y_cnt + 10'd1;
                    end
                end else begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end
        end
    end

    always_comb begin
        de_raw = (x_cnt < 11'(H_ACT)) && (y_cnt < 10'(V_ACT));
        hs_raw = !((x_cnt >= 11'(HS_START)) && (x_cnt < 11'(HS_END)));
        vs_raw = !((y_cnt >= 10'(VS_START)) && (y_cnt < 10'(VS_END)));
    end

    sync_delay_line #(
        .Depth(PIPE_DELAY),
        .Width(3)
    ) u_sync_delay_line (
        .clk    (clk),
        .reset  (reset),
        .rst_val(3'b110),
        .d      ({hs_raw, vs_raw, de_raw}),
        .q      (sync_dly)
    );

    // The extra output register matches the renderer's registered colour output.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_hsd <= 1'b1;
            lcd_vsd <= 1'b1;
            lcd_de  <= 1'b0;
            lcd_rgb <= BLANK_RGB;
        end else begin
            lcd_hsd <= sync_dly[2];
            lcd_vsd <= sync_dly[1];
            lcd_de  <= sync_dly[0];
            lcd_rgb <= sync_dly[0] ? pixel_rgb : BLANK_RGB;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a shrunk 14x9 raster: per-clk model compare plus literal checks.
module tb_lcd_timing_gen;

    localparam int HA = 8;
    localparam int HF = 3;
    localparam int HS = 1;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 2;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 14
    localparam int VT = VA + VF + VS + VB;   // 9

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } out_t;

    localparam out_t INACT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 24'h0};

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [23:0] pixel_rgb;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        frame_start;
    logic        lcd_hsd;
    logic        lcd_vsd;
    logic        lcd_de;
    logic [23:0] lcd_rgb;

    int checks = 0;
    int errors = 0;

    lcd_timing_gen #(
        .H_ACTIVE  (HA),
        .H_FRONT   (HF),
        .H_SYNC    (HS),
        .H_BACK    (HB),
        .V_ACTIVE  (VA),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB),
        .PIPE_DELAY(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .pixel_rgb  (pixel_rgb),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .frame_start(frame_start),
        .lcd_hsd    (lcd_hsd),
        .lcd_vsd    (lcd_vsd),
        .lcd_de     (lcd_de),
        .lcd_rgb    (lcd_rgb)
    );

    always #5 clk = ~clk;

    // Renderer stand-in: 3-clk latency from counters to colour.
    logic [23:0] ren1 = 24'h0;
    logic [23:0] ren2 = 24'h0;
    initial pixel_rgb = 24'h0;
    always @(posedge clk) begin
        ren1      <= {x_cnt[7:0], y_cnt[7:0], 8'hA5};
        ren2      <= ren1;
        pixel_rgb <= ren2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Panel outputs are the region rule applied to the counter value from 4 clk earlier.
    function automatic out_t region(input int x, input int y);
        out_t o;
        o.de  = (x < HA) && (y < VA);
        o.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        o.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        o.rgb = o.de ? {8'(x), 8'(y), 8'hA5} : 24'h0;
        return o;
    endfunction

    out_t q[$];
    out_t exp_o;
    int   mx;
    int   my;
    bit   mfs;
    bit   started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mx = 0;
            my = 0;
            mfs = 1'b0;
            q.delete();
            for (int i = 0; i < 3; i++) q.push_back(INACT);
            exp_o = INACT;
            started = 1'b1;
        end else if (started) begin
            int idx;
            q.push_back(region(mx, my));
            exp_o = q.pop_front();
            mfs = 1'b0;
            if (pix_en) begin
                idx = (my * HT + mx + 1) % (HT * VT);
                mx  = idx % HT;
                my  = idx / HT;
                mfs = (idx == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("x_cnt", 32'(x_cnt), 32'(mx));
            check("y_cnt", 32'(y_cnt), 32'(my));
            check("frame_start", 32'(frame_start), 32'(mfs));
            check("lcd_hsd", 32'(lcd_hsd), 32'(exp_o.hs));
            check("lcd_vsd", 32'(lcd_vsd), 32'(exp_o.vs));
            check("lcd_de", 32'(lcd_de), 32'(exp_o.de));
            check("lcd_rgb", 32'(lcd_rgb), 32'(exp_o.rgb));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle();
        check("rst_x", 32'(x_cnt), 32'd0);
        check("rst_y", 32'(y_cnt), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_hsd", 32'(lcd_hsd), 32'd1);
        check("rst_vsd", 32'(lcd_vsd), 32'd1);
        check("rst_de", 32'(lcd_de), 32'd0);
        check("rst_rgb", 32'(lcd_rgb), 32'd0);
    endtask

    // Called right after reset release with pix_en=1; runs 140 clk.
    task automatic measure_frame();
        int pulse_idx = -1;
        int npulse = 0;
        int vs_low = 0;
        int hs_low = 0;
        int hs_idx = -1;
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            if (frame_start) begin
                npulse++;
                if (pulse_idx < 0) pulse_idx = i;
            end
            if (!lcd_vsd) vs_low++;
            if (!lcd_hsd && i < HT + 4) begin
                hs_low++;
                hs_idx = i;
            end
            if (i == 4) check("rgb_origin", 32'(lcd_rgb), 32'h0000A5);
            if (i == 5) check("rgb_x1", 32'(lcd_rgb), 32'h0100A5);
            if (i == 14) begin
                check("wrap_x", 32'(x_cnt), 32'd0);
                check("wrap_y", 32'(y_cnt), 32'd1);
            end
            if (i == 17) check("rgb_blank", 32'(lcd_rgb), 32'd0);
        end
        check("fs_count", 32'(npulse), 32'd1);
        check("fs_index", 32'(pulse_idx), 32'd126);
        check("vsd_low_clks", 32'(vs_low), 32'd14);
        check("hsd_low_clks", 32'(hs_low), 32'd1);
        check("hsd_low_index", 32'(hs_idx), 32'd15);
    endtask

    initial begin
        int de_cnt;
        reset  = 1'b1;
        pix_en = 1'b0;
        do_reset();
        check_idle();
        pix_en = 1'b1;
        measure_frame();

        // Move to (4,2) of the second frame, then reset mid-frame.
        repeat (18) @(negedge clk);
        check("pre_rst_x", 32'(x_cnt), 32'd4);
        check("pre_rst_y", 32'(y_cnt), 32'd2);
        do_reset();
        check_idle();
        measure_frame();

        // pix_en 1-of-2: each counter value lasts 2 clk.
        pix_en = 1'b0;
        do_reset();
        de_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            pix_en = (i % 2 == 1);
            @(negedge clk);
            if (i + 1 >= 4 && i + 1 <= 255 && lcd_de) de_cnt++;
            if (i + 1 == 27) check("half_x27", 32'(x_cnt), 32'd13);
            if (i + 1 == 28) begin
                check("half_x28", 32'(x_cnt), 32'd0);
                check("half_y28", 32'(y_cnt), 32'd1);
            end
        end
        check("half_de_clks", 32'(de_cnt), 32'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
